// File: rtl/bmp_byte_packer.sv
// bmp_byte_packer: serializes 24-bit RGB pixels into BMP byte order (B, G, R),
// appending zero bytes so every row is a multiple of four bytes long.
// Optional feature macro: BMP_ROW_PAD_EN. When it is undefined, rows are never
// padded and m_last marks the R byte of each row-final pixel.
module bmp_byte_packer #(
  parameter int DST_WIDTH  = 3840,
  parameter int DST_HEIGHT = 2160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        frame_done
);

`ifdef BMP_ROW_PAD_EN
  localparam int PADN = (4 - ((DST_WIDTH * 3) % 4)) % 4;
`else
  localparam int PADN = 0;
`endif

  localparam logic [1:0]  PAD_LAST = 2'((PADN > 0) ? PADN - 1 : 0);
  localparam logic [15:0] COL_MAX  = 16'(DST_WIDTH - 1);
  localparam logic [15:0] ROW_MAX  = 16'(DST_HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, BYTE2, PAD} state_t;

  state_t      state;
  logic [23:0] pix;
  logic [15:0] col;
  logic [15:0] row;
  logic [1:0]  pad_cnt;
  logic        eof_pend;   // the row being padded is the last of the frame

  logic last_col, last_row, pad_row;
  assign last_col = (col == COL_MAX);
  assign last_row = (row == ROW_MAX);
  assign pad_row  = last_col && (PADN > 0);

  // Accept a new pixel when idle, or in the R-byte cycle as it drains
  // (back-to-back), unless that R byte is followed by row padding.
  assign s_ready = !rst && ((state == IDLE) ||
                            (state == BYTE2 && m_ready && !pad_row));

  // Byte sequencer with registered output stage and position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pix        <= '0;
      col        <= '0;
      row        <= '0;
      pad_cnt    <= '0;
      eof_pend   <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= 8'h00;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid) begin
            pix     <= s_data;
            m_data  <= s_data[7:0];
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            state   <= BYTE0;
          end
        end
        BYTE0: begin
          if (m_ready) begin
            m_data <= pix[15:8];
            state  <= BYTE1;
          end
        end
        BYTE1: begin
          if (m_ready) begin
            m_data <= pix[23:16];
            m_last <= last_col && (PADN == 0);
            state  <= BYTE2;
          end
        end
        BYTE2: begin
          if (m_ready) begin
            if (last_col) begin
              col <= '0;
              row <= last_row ? 16'd0 : row + 16'd1;
            end else begin
              col <= col + 16'd1;
            end
            if (pad_row) begin
              state    <= PAD;
              pad_cnt  <= 2'd0;
              m_data   <= 8'h00;
              m_last   <= (PAD_LAST == 2'd0);
              eof_pend <= last_row;
            end else begin
              frame_done <= last_col && last_row;
              if (s_valid) begin
                pix     <= s_data;
                m_data  <= s_data[7:0];
                m_last  <= 1'b0;
                state   <= BYTE0;
              end else begin
                m_valid <= 1'b0;
                m_data  <= 8'h00;
                m_last  <= 1'b0;
                state   <= IDLE;
              end
            end
          end
        end
        PAD: begin
          if (m_ready) begin
            if (pad_cnt == PAD_LAST) begin
              m_valid    <= 1'b0;
              m_last     <= 1'b0;
              frame_done <= eof_pend;
              state      <= IDLE;
            end else begin
              pad_cnt <= pad_cnt + 2'd1;
              m_last  <= (pad_cnt + 2'd1 == PAD_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_byte_packer.sv
// Bench for bmp_byte_packer: scoreboard of expected bytes built from accepted
// pixels, plus directed stall, throttled input, mid-row reset and wide-row cases.
module tb_bmp_byte_packer;
  localparam int W = 5;
  localparam int H = 2;
`ifdef BMP_ROW_PAD_EN
  localparam int PADN = 1;   // 15 bytes per row -> one pad byte
`else
  localparam int PADN = 0;
`endif
  localparam int FB = W * 3 * H + PADN * H;

  logic clk, rst;
  logic s_valid, s_ready, m_valid, m_ready, m_last, frame_done;
  logic [23:0] s_data;
  logic [7:0]  m_data;
  logic s_valid2, s_ready2, m_valid2, m_ready2, m_last2, fd2;
  logic [23:0] s_data2;
  logic [7:0]  m_data2;

  bmp_byte_packer #(.DST_WIDTH(W), .DST_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_done(frame_done));

  bmp_byte_packer #(.DST_WIDTH(3840), .DST_HEIGHT(1)) dut_w (
    .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2),
    .frame_done(fd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int nbytes = 0, nfd = 0;
  int mcol = 0, mrow = 0;
  bit fd_exp = 1'b0;
  logic [9:0] q[$];   // {eof, last, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] px(input int k);
    return {8'(3 * k + 1), 8'(3 * k + 2), 8'(3 * k + 3)};
  endfunction

  // Expected byte stream for one accepted pixel, tracking row position.
  task automatic model_px(input logic [23:0] d);
    bit lc, eof;
    lc  = (mcol == W - 1);
    eof = lc && (mrow == H - 1);
    q.push_back({2'b00, d[7:0]});
    q.push_back({2'b00, d[15:8]});
    q.push_back({eof && (PADN == 0), lc && (PADN == 0), d[23:16]});
    if (lc)
      for (int i = 0; i < PADN; i++)
        q.push_back({eof && (i == PADN - 1), i == PADN - 1, 8'h00});
    if (lc) begin
      mcol = 0;
      mrow = (mrow == H - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  // Monitor: compares output bytes against the scoreboard away from the edge.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      q.delete();
      mcol = 0;
      mrow = 0;
      fd_exp = 1'b0;
    end else begin
      chk("frame_done", frame_done, fd_exp);
      fd_exp = 1'b0;
      chk("m_valid_pending", m_valid, q.size() != 0);
      if (m_valid && m_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("m_data", m_data, e[7:0]);
        chk("m_last", m_last, e[8]);
        fd_exp = e[9];
        nbytes++;
      end
      if (frame_done) nfd++;
      if (s_valid && s_ready) model_px(s_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1; holds the pixel until it is accepted.
  task automatic send(input logic [23:0] d);
    bit hs;
    hs = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      hs = s_ready;
      step();
    end
    s_valid = 1'b0;
    s_data  = 24'($urandom);
    chk("send_accept", hs, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (q.size() != 0 || m_valid); n++) step();
    chk("drain_empty", q.size(), 0);
    repeat (2) step();
  endtask

  initial begin
    int k, cyc, cnt, zeros;
    bit hs, got;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    s_valid2 = 1'b0; s_data2 = '0; m_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_s_ready_w", s_ready2, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_rst", s_ready, 1);
    step();

    // Frame 1: continuous stream.
    nbytes = 0; nfd = 0;
    for (int i = 0; i < W * H; i++) send(px(i));
    drain();
    chk("frame1_bytes", nbytes, FB);
    chk("frame1_fd", nfd, 1);

    // Frame 2: stall on G=0xAB, then throttled input.
    nbytes = 0; nfd = 0;
    send(24'h56AB12);
    step();
    m_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_m_data", m_data, 8'hAB);
      chk("stall_m_valid", m_valid, 1);
      chk("stall_s_ready", s_ready, 0);
      step();
    end
    m_ready = 1'b1;
    k = 1; cyc = 0;
    while (k < W * H && cyc < 300) begin
      s_valid = cyc[0];
      s_data  = px(k);
      @(negedge clk);
      hs = s_valid && s_ready;
      step();
      if (hs) k++;
      cyc++;
    end
    s_valid = 1'b0;
    chk("toggle_all_sent", k, W * H);
    drain();
    chk("frame2_bytes", nbytes, FB);
    chk("frame2_fd", nfd, 1);

    // Reset while in BYTE1 mid-row, then a clean frame.
    send(px(20));
    send(px(21));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    repeat (3) step();
    @(negedge clk);
    chk("midrst_quiet", m_valid, 0);
    step();
    nbytes = 0; nfd = 0;
    for (int i = 0; i < W * H; i++) send(px(i + 30));
    drain();
    chk("frame3_bytes", nbytes, FB);
    chk("frame3_fd", nfd, 1);

    // Wide row: 3840*3 is a multiple of four, so no pad bytes ever.
    s_valid2 = 1'b1;
    s_data2  = 24'hA5C3E1;
    cnt = 0; zeros = 0; got = 1'b0;
    for (int n = 0; n < 12000 && !got; n++) begin
      @(negedge clk);
      if (m_valid2 && m_ready2) begin
        cnt++;
        if (m_data2 == 8'h00) zeros++;
        if (m_last2) got = 1'b1;
      end
      step();
    end
    s_valid2 = 1'b0;
    @(negedge clk);
    chk("wide_frame_done", fd2, 1);
    chk("wide_last_seen", got, 1);
    chk("wide_bytes", cnt, 11520);
    chk("wide_no_pad", zeros, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
